// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for the shared ALU.
// One command in flight: issue pulse, bounded wait for result, held response.
module alu_req_arbiter #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32,
    parameter int TIMEOUT   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ0_VALID,
    output logic                 REQ0_READY,
    input  logic [3:0]           REQ0_FUNC,
    input  logic [WIDTH-1:0]     REQ0_A,
    input  logic [WIDTH-1:0]     REQ0_B,
    input  logic                 REQ1_VALID,
    output logic                 REQ1_READY,
    input  logic [3:0]           REQ1_FUNC,
    input  logic [WIDTH-1:0]     REQ1_A,
    input  logic [WIDTH-1:0]     REQ1_B,
    output logic                 ALU_EN,
    output logic [3:0]           ALU_FUNC,
    output logic [WIDTH-1:0]     ALU_A,
    output logic [WIDTH-1:0]     ALU_B,
    input  logic [OUT_WIDTH-1:0] ALU_OUT,
    input  logic                 ALU_OUT_VALID,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic                 RSP_ID,
    output logic [OUT_WIDTH-1:0] RSP_DATA,
    output logic                 RSP_ERR,
    output logic                 BUSY
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_ptr;
    logic [CW-1:0]        r_cnt;
    logic                 r_alu_en;
    logic [3:0]           r_alu_func;
    logic [WIDTH-1:0]     r_alu_a;
    logic [WIDTH-1:0]     r_alu_b;
    logic                 r_rsp_valid;
    logic                 r_rsp_id;
    logic [OUT_WIDTH-1:0] r_rsp_data;
    logic                 r_rsp_err;

    logic w_gnt0;
    logic w_gnt1;
    logic w_accept;
    logic w_rsp_hs;
    logic w_tmo;

    // Pointer only matters when both requesters contend.
    assign w_gnt0   = REQ0_VALID && (!REQ1_VALID || !r_ptr);
    assign w_gnt1   = REQ1_VALID && (!REQ0_VALID || r_ptr);
    assign w_accept = (r_state == S_IDLE) && (w_gnt0 || w_gnt1);
    assign w_rsp_hs = r_rsp_valid && RSP_READY;
    assign w_tmo    = (r_cnt == TMAX);

    always_comb begin
        w_next     = r_state;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                REQ0_READY = w_gnt0;
                REQ1_READY = w_gnt1;
                if (w_accept) w_next = S_ISSUE;
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (ALU_OUT_VALID || w_tmo) w_next = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_hs) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr       <= 1'b0;
            r_cnt       <= '0;
            r_alu_en    <= 1'b0;
            r_alu_func  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_alu_en <= w_accept;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_func <= w_gnt1 ? REQ1_FUNC : REQ0_FUNC;
                        r_alu_a    <= w_gnt1 ? REQ1_A : REQ0_A;
                        r_alu_b    <= w_gnt1 ? REQ1_B : REQ0_B;
                        r_rsp_id   <= w_gnt1;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    // A result in the last wait cycle still beats the timeout.
                    if (ALU_OUT_VALID) begin
                        r_rsp_data  <= ALU_OUT;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                    end else if (w_tmo) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= ~r_rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ALU_EN    = r_alu_en;
    assign ALU_FUNC  = r_alu_func;
    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_ID    = r_rsp_id;
    assign RSP_DATA  = r_rsp_data;
    assign RSP_ERR   = r_rsp_err;
    assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: directed commands, ALU model,
// monitor checking issue pulses, latency and responses.
module tb_alu_req_arbiter;

    localparam int W  = 16;
    localparam int OW = 32;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ0_VALID, REQ0_READY;
    logic [3:0]    REQ0_FUNC;
    logic [W-1:0]  REQ0_A, REQ0_B;
    logic          REQ1_VALID, REQ1_READY;
    logic [3:0]    REQ1_FUNC;
    logic [W-1:0]  REQ1_A, REQ1_B;
    logic          ALU_EN;
    logic [3:0]    ALU_FUNC;
    logic [W-1:0]  ALU_A, ALU_B;
    logic [OW-1:0] ALU_OUT;
    logic          ALU_OUT_VALID;
    logic          RSP_VALID, RSP_READY, RSP_ID, RSP_ERR, BUSY;
    logic [OW-1:0] RSP_DATA;

    alu_req_arbiter #(.WIDTH(W), .OUT_WIDTH(OW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
        .REQ0_FUNC(REQ0_FUNC), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
        .REQ1_FUNC(REQ1_FUNC), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
        .ALU_EN(ALU_EN), .ALU_FUNC(ALU_FUNC), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  func;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    typedef struct {
        logic        id;
        logic [3:0]  func;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    cmd_t q0[$];
    cmd_t q1[$];
    exp_t sb[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = -100;
    int hs_cyc = -100;

    int          alu_lat = 1;
    bit          alu_force = 1'b0;
    logic [7:0]  en_sr;
    logic [31:0] alu_res;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] model(logic [3:0] f, logic [15:0] a,
                                          logic [15:0] b);
        case (f)
            4'b0000: model = {16'h0, a} + {16'h0, b};
            4'b0100: model = {16'h0, a & b};
            default: model = 32'h0;
        endcase
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // ALU model: result alu_lat cycles after ALU_EN, never when alu_lat==0
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            en_sr   <= '0;
            alu_res <= '0;
        end else begin
            en_sr <= {en_sr[6:0], ALU_EN};
            if (ALU_EN)
                alu_res <= alu_force ? 32'h12 : model(ALU_FUNC, ALU_A, ALU_B);
        end
    end

    always_comb begin
        ALU_OUT_VALID = 1'b0;
        if (alu_lat >= 1 && alu_lat <= 8) ALU_OUT_VALID = en_sr[alu_lat-1];
    end
    assign ALU_OUT = alu_res;

    initial begin
        bit hs;
        REQ0_VALID = 0; REQ0_FUNC = 0; REQ0_A = 0; REQ0_B = 0;
        forever begin
            if (q0.size() > 0) begin
                REQ0_VALID = 1;
                REQ0_FUNC = q0[0].func; REQ0_A = q0[0].a; REQ0_B = q0[0].b;
            end else begin
                REQ0_VALID = 0;
            end
            @(negedge CLK);
            hs = REQ0_VALID && REQ0_READY;
            @(posedge CLK);
            #1;
            if (hs) void'(q0.pop_front());
        end
    end

    initial begin
        bit hs;
        REQ1_VALID = 0; REQ1_FUNC = 0; REQ1_A = 0; REQ1_B = 0;
        forever begin
            if (q1.size() > 0) begin
                REQ1_VALID = 1;
                REQ1_FUNC = q1[0].func; REQ1_A = q1[0].a; REQ1_B = q1[0].b;
            end else begin
                REQ1_VALID = 0;
            end
            @(negedge CLK);
            hs = REQ1_VALID && REQ1_READY;
            @(posedge CLK);
            #1;
            if (hs) void'(q1.pop_front());
        end
    end

    // Monitor
    initial begin
        logic en_prev;
        logic v_prev;
        exp_t e;
        en_prev = 0;
        v_prev = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                en_prev = 0;
                v_prev = 0;
                continue;
            end
            if ((REQ0_VALID && REQ0_READY) || (REQ1_VALID && REQ1_READY))
                acc_cyc = cyc;
            if (ALU_EN) begin
                chk("alu_en_pulse", en_prev, 0);
                if (sb.size() == 0) begin
                    chk("alu_en_unexpected", ALU_EN, 0);
                end else begin
                    chk("alu_en_lat", cyc - acc_cyc, 1);
                    chk("alu_func", ALU_FUNC, sb[0].func);
                    chk("alu_a", ALU_A, sb[0].a);
                    chk("alu_b", ALU_B, sb[0].b);
                end
            end
            if (RSP_VALID && !v_prev) begin
                if (sb.size() == 0) chk("rsp_unexpected", RSP_VALID, 0);
                else chk("rsp_lat", cyc - acc_cyc, sb[0].lat);
            end
            if (RSP_VALID && RSP_READY) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", RSP_VALID, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", RSP_ID, e.id);
                    chk("rsp_data", RSP_DATA, e.data);
                    chk("rsp_err", RSP_ERR, e.err);
                end
                hs_cyc = cyc;
            end
            en_prev = ALU_EN;
            v_prev = RSP_VALID;
        end
    end

    task automatic add(bit id, logic [3:0] f, logic [15:0] a, logic [15:0] b,
                       logic [31:0] d, bit err, int lat);
        cmd_t c;
        c = '{f, a, b};
        if (id) q1.push_back(c);
        else    q0.push_back(c);
        sb.push_back(exp_t'{id, f, a, b, d, err, lat});
    endtask

    task automatic wait_done(string nm);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || BUSY)
               && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_done"}, n < 400, 1);
    endtask

    logic [15:0] ca[4]   = '{16'd1, 16'hFFFF, 16'd100, 16'h8000};
    logic [15:0] cb[4]   = '{16'd2, 16'h0001, 16'd23, 16'h8000};
    logic [31:0] cexp[4] = '{32'd3, 32'h10000, 32'd123, 32'h10000};

    initial begin
        logic [33:0] snap;
        int n;
        RSP_READY = 1;
        #12;
        chk("reset_ctrl", {ALU_EN, ALU_FUNC, ALU_A, ALU_B,
                           RSP_VALID, RSP_ID, RSP_ERR, BUSY}, 0);
        chk("reset_data", RSP_DATA, 0);
        @(negedge CLK);
        RST = 0;
        repeat (2) @(negedge CLK);

        // contention: strict alternation starting with requester 0
        for (int i = 0; i < 4; i++) begin
            add(0, 4'b0000, ca[i], cb[i], cexp[i], 0, 3);
            add(1, 4'b0100, 16'h00F0, 16'h0F0F, 32'h0, 0, 3);
        end
        wait_done("contention");

        add(0, 4'b0000, 16'd5, 16'd3, 32'd8, 0, 3);
        wait_done("single_add");

        alu_lat = 0;
        add(0, 4'b0000, 16'd7, 16'd9, 32'h0, 1, 2 + TO);
        wait_done("timeout");
        alu_lat = 1;
        add(1, 4'b0100, 16'hFF00, 16'h0FF0, 32'h0F00, 0, 3);
        wait_done("after_timeout");

        alu_lat = TO;
        alu_force = 1;
        add(0, 4'b0000, 16'd1, 16'd1, 32'h12, 0, 2 + TO);
        wait_done("same_cycle");
        alu_lat = 1;
        alu_force = 0;

        // backpressure with requester 1 waiting
        RSP_READY = 0;
        add(0, 4'b0000, 16'h1234, 16'h1111, 32'h2345, 0, 3);
        n = 0;
        while (q0.size() > 0 && n < 50) begin @(negedge CLK); n++; end
        add(1, 4'b0100, 16'h0F0F, 16'h00FF, 32'h000F, 0, 3);
        n = 0;
        while (!RSP_VALID && n < 50) begin @(negedge CLK); n++; end
        chk("bp_rsp_seen", RSP_VALID, 1);
        snap = {RSP_ID, RSP_DATA, RSP_ERR};
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_stable", {RSP_ID, RSP_DATA, RSP_ERR}, snap);
            chk("bp_ctrl", {RSP_VALID, BUSY, REQ1_READY, REQ1_VALID}, 4'b1101);
        end
        @(posedge CLK);
        #1;
        RSP_READY = 1;
        n = 0;
        while (q1.size() > 0 && n < 50) begin @(negedge CLK); n++; end
        chk("bp_accept_after_hs", acc_cyc - hs_cyc, 1);
        wait_done("backpressure");

        // leaves pointer at 1 so reset must visibly restore it
        add(0, 4'b0000, 16'd10, 16'd20, 32'd30, 0, 3);
        wait_done("lone_req0");

        alu_lat = 0;
        add(0, 4'b0000, 16'hABCD, 16'h0001, 32'h0, 0, 3);
        n = 0;
        while (!ALU_EN && n < 50) begin @(negedge CLK); n++; end
        @(negedge CLK);
        #2;
        RST = 1;
        #1;
        chk("midrst_ctrl", {ALU_EN, ALU_FUNC, ALU_A, ALU_B,
                            RSP_VALID, RSP_ID, RSP_ERR, BUSY}, 0);
        chk("midrst_data", RSP_DATA, 0);
        sb.delete();
        @(negedge CLK);
        RST = 0;
        alu_lat = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("no_rsp_after_reset", RSP_VALID, 0);
        end

        add(0, 4'b0000, 16'd2, 16'd2, 32'd4, 0, 3);
        add(1, 4'b0100, 16'hFFFF, 16'h00FF, 32'h00FF, 0, 3);
        wait_done("post_reset_contention");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
